alu_rr_scheduler: RTL and testbench
===================================

# alu_rr_scheduler

Round-robin scheduler that shares one combinational 128-bit ALU among NUM_REQ requesters. Each request carries opcode, two operands and a shift amount. The scheduler grants one requester, drives the ALU from registered operands, captures result and flags one cycle later, and returns them with the requester ID over a valid/ready response port. It sits between requester engines and the ALU instance.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- WIDTH, 128: operand/result width; must match the ALU.
- SHW, 5: shift-amount width.
- IDW, 2: requester ID width; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_opcode  in  NUM_REQ*4  opcodes, requester i at [4i+3:4i].
- req_a, req_b  in  NUM_REQ*WIDTH  operands, requester i at [WIDTH*i+WIDTH-1:WIDTH*i].
- req_shift  in  NUM_REQ*SHW  shift amounts.
- alu_opcode  out  4  to ALU opcode.
- alu_in1, alu_in2  out  WIDTH  to ALU input1/input2.
- alu_shift  out  SHW  to ALU shiftValue.
- alu_result  in  WIDTH  from ALU result.
- alu_carry, alu_zero, alu_ovf  in  1  from ALU flags.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  IDW  requester index that owns the response.
- resp_result  out  WIDTH  captured result.
- resp_carry, resp_zero, resp_ovf  out  1  captured flags.
- resp_err  out  1  opcode was unsupported (8..15).
- busy  out  1  high in any state except IDLE.
- op_count  out  32  completed responses; wraps at 2^32.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: the grant is the first requester with req_valid set, searching from (last_grant+1) mod NUM_REQ upward with wrap. req_ready for the grant is asserted combinationally in the same cycle. All other req_ready bits are 0. No req_valid -> stay IDLE, all req_ready 0.
- Accept edge: register the granted opcode/a/b/shift into the alu_* output registers, set last_grant and resp_id to the grant, then go to EXEC.
- EXEC (one cycle): the ALU evaluates the registered operands. At the end of the cycle:
  - opcode[3]=0: capture alu_result and the ALU flags; resp_err=0.
  - opcode[3]=1: resp_result=0, carry=0, zero=1, ovf=0, resp_err=1. ALU outputs are ignored.
  - Either way, go to RESP.
- RESP: resp_valid=1. resp_* fields stay stable until resp_ready. On resp_valid&resp_ready: op_count+1, go to IDLE. No new request is accepted in RESP or EXEC.
- alu_* outputs hold their last values while idle; they change only on an accept edge.
- req_valid may drop in IDLE before a grant without any effect. Once accepted, a request is owned by the scheduler and its inputs are no longer sampled.

## Timing
- Reset values: state IDLE; last_grant=NUM_REQ-1 (requester 0 wins first); alu_*=0; resp_valid=0; resp_id=0; resp_result=0; all resp flags and resp_err=0; busy=0; op_count=0; req_ready=0.
- Latency: accept at edge E0 -> resp_valid high after E1 -> earliest completion at E2 -> next accept no earlier than E3. Peak throughput is 1 op per 3 cycles.
- busy is high from E0 until the response handshake edge.
- Reset asserted mid-operation: the in-flight op is dropped with no response, and all registers return to their reset values immediately. On release, the first grant again favours requester 0.
- All requesters valid continuously: grants rotate 0,1,2,3,0,... Each requester waits at most NUM_REQ-1 other grants.
- op_count rolls from 0xFFFFFFFF to 0 without side effects.

## Test plan
- Single op: req 2 sends ADD (op 6), a=5, b=7; resp_ready=1 -> req_ready[2] in the same cycle; resp_valid two edges later with id=2, result=12, zero=0; op_count=1.
- Fairness: all four req_valid held high with distinct ops, resp_ready=1 -> grant/resp_id order 0,1,2,3,0,1; one accept every 3 cycles.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_* fields stable, req_ready all 0, busy=1; then resp_ready=1 -> one handshake, op_count+1.
- Illegal opcode: req 1 sends op 12 -> resp_err=1, result=0, zero=1, carry=0, ovf=0, id=1.
- Async reset: assert rst_n=0 while in EXEC -> immediately resp_valid=0, busy=0, alu_*=0; after release, req 3 and req 0 both valid -> req 0 granted first.
- Wrap: force op_count to 0xFFFFFFFF and complete one op -> op_count=0.

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// -----------------------------------------------------------------------------
// alu_rr_scheduler
//
// Shares one combinational ALU among NUM_REQ requesters. A round-robin arbiter
// picks one valid requester in IDLE, latches its opcode/operands/shift into
// registers that drive the ALU, captures the ALU result and flags one cycle
// later, and presents them with the owning requester ID on a valid/ready
// response port.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      per-requester handshake (req_ready one-hot or 0)
//   req_opcode/a/b/shift       packed per-requester request fields
//   alu_opcode/in1/in2/shift   registered operands driving the shared ALU
//   alu_result/carry/zero/ovf  ALU outputs, sampled at the end of EXEC
//   resp_valid / resp_ready    response handshake
//   resp_id/result/flags/err   captured response fields
//   busy                       high whenever an operation is in flight
//   op_count                   completed responses, wraps at 2^32
// -----------------------------------------------------------------------------
module alu_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 128,
  parameter int SHW     = 5,
  parameter int IDW     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*4-1:0]     req_opcode,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*SHW-1:0]   req_shift,
  output logic [3:0]               alu_opcode,
  output logic [WIDTH-1:0]         alu_in1,
  output logic [WIDTH-1:0]         alu_in2,
  output logic [SHW-1:0]           alu_shift,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_carry,
  input  logic                     alu_zero,
  input  logic                     alu_ovf,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IDW-1:0]           resp_id,
  output logic [WIDTH-1:0]         resp_result,
  output logic                     resp_carry,
  output logic                     resp_zero,
  output logic                     resp_ovf,
  output logic                     resp_err,
  output logic                     busy,
  output logic [31:0]              op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;
  logic           grant_vld;
  logic           accept;
  logic [31:0]    cnt_q;
  int             idx;

  // Search starts just after the previous winner and wraps, so every
  // continuously-valid requester waits at most NUM_REQ-1 other grants.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_grant;
    idx       = 0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDW'(idx);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign accept     = (state == IDLE) && grant_vld;
  // Gated by rst_n so no requester sees an accept while reset is held.
  assign req_ready  = (rst_n && accept) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);
  assign op_count   = cnt_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= IDW'(NUM_REQ - 1);
      alu_opcode  <= '0;
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_shift   <= '0;
      resp_id     <= '0;
      resp_result <= '0;
      resp_carry  <= 1'b0;
      resp_zero   <= 1'b0;
      resp_ovf    <= 1'b0;
      resp_err    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state <= state_nxt;
      // Accept edge: the request is copied in; requester inputs are not
      // looked at again until the next grant.
      if (accept) begin
        alu_opcode <= req_opcode[4*grant_idx +: 4];
        alu_in1    <= req_a[WIDTH*grant_idx +: WIDTH];
        alu_in2    <= req_b[WIDTH*grant_idx +: WIDTH];
        alu_shift  <= req_shift[SHW*grant_idx +: SHW];
        last_grant <= grant_idx;
        resp_id    <= grant_idx;
      end
      // End of EXEC: opcodes 8..15 are unsupported, so the ALU outputs are
      // discarded and a fixed error response is produced instead.
      if (state == EXEC) begin
        if (alu_opcode[3]) begin
          resp_result <= '0;
          resp_carry  <= 1'b0;
          resp_zero   <= 1'b1;
          resp_ovf    <= 1'b0;
          resp_err    <= 1'b1;
        end else begin
          resp_result <= alu_result;
          resp_carry  <= alu_carry;
          resp_zero   <= alu_zero;
          resp_ovf    <= alu_ovf;
          resp_err    <= 1'b0;
        end
      end
      // Response handshake
      if ((state == RESP) && resp_ready) cnt_q <= cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
module tb_alu_rr_scheduler;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 128;
  localparam int SHW     = 5;
  localparam int IDW     = 2;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*4-1:0]     req_opcode;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*SHW-1:0]   req_shift;
  logic [3:0]               alu_opcode;
  logic [WIDTH-1:0]         alu_in1;
  logic [WIDTH-1:0]         alu_in2;
  logic [SHW-1:0]           alu_shift;
  logic [WIDTH-1:0]         alu_result;
  logic                     alu_carry;
  logic                     alu_zero;
  logic                     alu_ovf;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [IDW-1:0]           resp_id;
  logic [WIDTH-1:0]         resp_result;
  logic                     resp_carry;
  logic                     resp_zero;
  logic                     resp_ovf;
  logic                     resp_err;
  logic                     busy;
  logic [31:0]              op_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_cnt;

  alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .SHW(SHW), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .req_shift(req_shift),
    .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shift(alu_shift),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_carry(resp_carry), .resp_zero(resp_zero),
    .resp_ovf(resp_ovf), .resp_err(resp_err), .busy(busy), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple stand-in ALU: 0 AND, 1 OR, 2 XOR, 6 ADD; anything else returns
  // XOR with carry/ovf set so that ignored outputs are visible if leaked.
  logic [WIDTH:0] sum;
  always_comb begin
    sum       = {1'b0, alu_in1} + {1'b0, alu_in2};
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (alu_opcode)
      4'd0: alu_result = alu_in1 & alu_in2;
      4'd1: alu_result = alu_in1 | alu_in2;
      4'd2: alu_result = alu_in1 ^ alu_in2;
      4'd6: begin
        alu_result = sum[WIDTH-1:0];
        alu_carry  = sum[WIDTH];
        alu_ovf    = (alu_in1[WIDTH-1] == alu_in2[WIDTH-1]) &&
                     (sum[WIDTH-1] != alu_in1[WIDTH-1]);
      end
      default: begin
        alu_result = alu_in1 ^ alu_in2;
        alu_carry  = 1'b1;
        alu_ovf    = 1'b1;
      end
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [SHW-1:0] sh);
    req_opcode[4*i +: 4]       = op;
    req_a[WIDTH*i +: WIDTH]    = a;
    req_b[WIDTH*i +: WIDTH]    = b;
    req_shift[SHW*i +: SHW]    = sh;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; resp_ready = 1'b0;
    req_opcode = '0; req_a = '0; req_b = '0; req_shift = '0;
    tick(); tick();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (op_count !== 32'd0) begin errors++; $display("FAIL rst_op_count: got %0d want 0", op_count); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    checks++; if (alu_in1 !== '0 || alu_opcode !== 4'd0 || alu_shift !== '0) begin errors++; $display("FAIL rst_alu: got op=%h in1=%h want 0", alu_opcode, alu_in1); end
    checks++; if (resp_result !== '0 || resp_id !== 2'd0 || resp_err !== 1'b0 || resp_zero !== 1'b0) begin errors++; $display("FAIL rst_resp_fields: got id=%0d res=%h err=%b z=%b want 0", resp_id, resp_result, resp_err, resp_zero); end
    req_valid = '0;
    rst_n = 1'b1;
    exp_cnt = 32'd0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL idle_no_valid: got %b want 0000", req_ready); end
  endtask

  task automatic test_fairness();
    logic [WIDTH-1:0] big;
    logic [WIDTH-1:0] er [4];
    logic ec [4];
    logic ez [4];
    logic eo [4];
    int g;
    big = '0; big[WIDTH-1] = 1'b1;
    set_req(0, 4'd0, 128'hF0, 128'h3C, 5'd3);
    set_req(1, 4'd1, 128'h0F, 128'h30, 5'd4);
    set_req(2, 4'd2, 128'hFF, 128'h0F, 5'd5);
    set_req(3, 4'd6, big, big, 5'd31);
    er[0] = 128'h30; er[1] = 128'h3F; er[2] = 128'hF0; er[3] = '0;
    ec[0] = 0; ec[1] = 0; ec[2] = 0; ec[3] = 1;
    ez[0] = 0; ez[1] = 0; ez[2] = 0; ez[3] = 1;
    eo[0] = 0; eo[1] = 0; eo[2] = 0; eo[3] = 1;
    req_valid = 4'b1111; resp_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      g = n % 4;
      #1;
      checks++; if (req_ready !== (4'b0001 << g)) begin errors++; $display("FAIL fair_grant%0d: got %b want %b", n, req_ready, 4'b0001 << g); end
      tick();
      checks++; if (alu_shift !== 5'(g + 3 + (g == 3 ? 25 : 0))) begin errors++; $display("FAIL fair_alu_shift%0d: got %0d", n, alu_shift); end
      tick();
      checks++; if (resp_valid !== 1'b1 || resp_id !== 2'(g)) begin errors++; $display("FAIL fair_resp_id%0d: got v=%b id=%0d want v=1 id=%0d", n, resp_valid, resp_id, g); end
      checks++; if (resp_result !== er[g] || resp_carry !== ec[g] || resp_zero !== ez[g] || resp_ovf !== eo[g]) begin
        errors++; $display("FAIL fair_resp_data%0d: got %h c%b z%b o%b want %h c%b z%b o%b", n, resp_result, resp_carry, resp_zero, resp_ovf, er[g], ec[g], ez[g], eo[g]);
      end
      tick();
      exp_cnt = exp_cnt + 1;
      checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL fair_count%0d: got %0d want %0d", n, op_count, exp_cnt); end
    end
    req_valid = '0;
  endtask

  task automatic test_single_op();
    set_req(2, 4'd6, 128'd5, 128'd7, 5'd9);
    req_valid = 4'b0100; resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL single_exec_state: got busy=%b v=%b want 1 0", busy, resp_valid); end
    checks++; if (alu_opcode !== 4'd6 || alu_in1 !== 128'd5 || alu_in2 !== 128'd7 || alu_shift !== 5'd9) begin
      errors++; $display("FAIL single_alu_regs: got op=%0d a=%0d b=%0d sh=%0d want 6 5 7 9", alu_opcode, alu_in1, alu_in2, alu_shift);
    end
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_result !== 128'd12 || resp_zero !== 1'b0 || resp_err !== 1'b0) begin
      errors++; $display("FAIL single_resp: got v=%b id=%0d res=%0d z=%b e=%b want 1 2 12 0 0", resp_valid, resp_id, resp_result, resp_zero, resp_err);
    end
    tick();
    exp_cnt = exp_cnt + 1;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0 || op_count !== exp_cnt) begin
      errors++; $display("FAIL single_done: got v=%b busy=%b cnt=%0d want 0 0 %0d", resp_valid, busy, op_count, exp_cnt);
    end
    checks++; if (alu_in1 !== 128'd5 || alu_opcode !== 4'd6) begin errors++; $display("FAIL single_alu_hold: got op=%0d a=%0d want 6 5", alu_opcode, alu_in1); end
  endtask

  task automatic test_backpressure();
    set_req(0, 4'd6, 128'd10, 128'd20, 5'd0);
    set_req(1, 4'd1, 128'd1, 128'd2, 5'd0);
    req_valid = 4'b0001; resp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_ready: got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b0011;
    tick();
    for (int n = 0; n < 5; n++) begin
      checks++; if (resp_valid !== 1'b1 || resp_result !== 128'd30 || resp_id !== 2'd0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b res=%0d id=%0d rdy=%b busy=%b want 1 30 0 0000 1", n, resp_valid, resp_result, resp_id, req_ready, busy);
      end
      checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL bp_count_hold%0d: got %0d want %0d", n, op_count, exp_cnt); end
      tick();
    end
    resp_ready = 1'b1;
    tick();
    exp_cnt = exp_cnt + 1;
    checks++; if (resp_valid !== 1'b0 || op_count !== exp_cnt) begin errors++; $display("FAIL bp_release: got v=%b cnt=%0d want 0 %0d", resp_valid, op_count, exp_cnt); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_next_grant: got %b want 0010", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_illegal();
    set_req(1, 4'd12, 128'd5, 128'd7, 5'd1);
    req_valid = 4'b0010; resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL ill_ready: got %b want 0010", req_ready); end
    tick();
    req_valid = '0;
    tick();
    checks++; if (resp_err !== 1'b1 || resp_result !== '0 || resp_zero !== 1'b1 || resp_carry !== 1'b0 || resp_ovf !== 1'b0 || resp_id !== 2'd1) begin
      errors++; $display("FAIL ill_resp: got e=%b res=%h z=%b c=%b o=%b id=%0d want 1 0 1 0 0 1", resp_err, resp_result, resp_zero, resp_carry, resp_ovf, resp_id);
    end
    tick();
    exp_cnt = exp_cnt + 1;
    checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL ill_count: got %0d want %0d", op_count, exp_cnt); end
  endtask

  task automatic test_async_reset();
    set_req(2, 4'd6, 128'd1, 128'd1, 5'd7);
    req_valid = 4'b0100; resp_ready = 1'b1;
    tick();
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL arst_state: got v=%b busy=%b want 0 0", resp_valid, busy); end
    checks++; if (alu_opcode !== 4'd0 || alu_in1 !== '0 || alu_in2 !== '0 || alu_shift !== '0) begin
      errors++; $display("FAIL arst_alu: got op=%0d a=%h b=%h sh=%0d want 0", alu_opcode, alu_in1, alu_in2, alu_shift);
    end
    checks++; if (op_count !== 32'd0) begin errors++; $display("FAIL arst_count: got %0d want 0", op_count); end
    exp_cnt = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(3, 4'd1, 128'd8, 128'd1, 5'd0);
    set_req(0, 4'd0, 128'hFF, 128'h0F, 5'd0);
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL arst_first_grant: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    tick();
    checks++; if (resp_id !== 2'd0 || resp_result !== 128'h0F) begin errors++; $display("FAIL arst_resp: got id=%0d res=%h want 0 0f", resp_id, resp_result); end
    tick();
    exp_cnt = exp_cnt + 1;
    checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL arst_count_after: got %0d want %0d", op_count, exp_cnt); end
  endtask

  task automatic test_wrap();
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    #1;
    checks++; if (op_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preset: got %h want ffffffff", op_count); end
    set_req(0, 4'd6, 128'd2, 128'd3, 5'd0);
    req_valid = 4'b0001; resp_ready = 1'b1;
    tick();
    req_valid = '0;
    tick();
    checks++; if (resp_result !== 128'd5) begin errors++; $display("FAIL wrap_resp: got %0d want 5", resp_result); end
    tick();
    checks++; if (op_count !== 32'd0 || busy !== 1'b0) begin errors++; $display("FAIL wrap_count: got %h busy=%b want 0 0", op_count, busy); end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single_op();
    test_backpressure();
    test_illegal();
    test_async_reset();
    @(negedge clk);
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
